// File: rtl/aip_demux_pkg.sv
// Shared types and defaults for the registered parametric demux.
// Frame occupancy state, default geometry and the slot-count helper.
package aip_demux_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } state_t;

  localparam int DEF_DATAWIDTH = 32;
  localparam int DEF_SELBITS   = 2;

  function automatic int slots(input int selbits);
    return 1 << selbits;
  endfunction

endpackage

// File: rtl/aip_demux_slot.sv
// One demux slot: a data register plus its written flag.
// clear drops only the flag; the stored word survives until the next write.
module aip_demux_slot #(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 we,
  input  logic [DATAWIDTH-1:0] d,
  output logic [DATAWIDTH-1:0] q,
  output logic                 valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (we) begin
      q     <= d;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/aip_parametric_demux_reg.sv
// Registered demux steering one word per accepted write into 2**SELBITS slots, with frame-full tracking.
// Optional sticky overflow port for dropped auto writes is enabled by AIP_DEMUX_OVERFLOW_EN.
module aip_parametric_demux_reg
  import aip_demux_pkg::*;
#(
  parameter  int DATAWIDTH = DEF_DATAWIDTH,
  parameter  int SELBITS   = DEF_SELBITS,
  localparam int SLOTS     = slots(SELBITS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       wr_en,
  input  logic                       auto_inc,
  input  logic [SELBITS-1:0]         sel,
  input  logic [DATAWIDTH-1:0]       data_in,
  output logic                       ready,
  output logic [SLOTS*DATAWIDTH-1:0] data_out,
  output logic [SLOTS-1:0]           slot_valid,
  output logic [SELBITS-1:0]         wr_ptr,
  output logic                       full,
  output logic                       done
`ifdef AIP_DEMUX_OVERFLOW_EN
  ,
  output logic                       overflow
`endif
);

  state_t             state;
  state_t             state_nxt;
  logic               accept;
  logic [SELBITS-1:0] tgt;
  logic [SLOTS-1:0]   we_vec;
  logic [SLOTS-1:0]   vld_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state follows the occupancy the slots will hold after this edge.
  always_comb begin
    ready     = !clear && !(auto_inc && state == FULL);
    accept    = wr_en && ready;
    tgt       = auto_inc ? wr_ptr : sel;
    we_vec    = '0;
    vld_nxt   = '0;
    state_nxt = state;
    if (accept) begin
      we_vec[tgt] = 1'b1;
    end
    if (!clear) begin
      vld_nxt = slot_valid | we_vec;
    end
    if (vld_nxt == '0) begin
      state_nxt = EMPTY;
    end else if (&vld_nxt) begin
      state_nxt = FULL;
    end else begin
      state_nxt = FILLING;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state_nxt == FULL) && (state != FULL);
      if (clear) begin
        wr_ptr <= '0;
      end else if (accept && auto_inc) begin
        wr_ptr <= wr_ptr + SELBITS'(1);
      end
    end
  end

  assign full = (state == FULL);

`ifdef AIP_DEMUX_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      overflow <= 1'b0;
    end else if (wr_en && auto_inc && state == FULL) begin
      overflow <= 1'b1;
    end
  end
`endif

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    aip_demux_slot #(
      .DATAWIDTH (DATAWIDTH)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .we    (we_vec[i]),
      .d     (data_in),
      .q     (data_out[i*DATAWIDTH +: DATAWIDTH]),
      .valid (slot_valid[i])
    );
  end

endmodule

// File: tb/tb_aip_parametric_demux_reg.sv
// Randomized and directed bench for aip_parametric_demux_reg against a slot-array reference model.
// Handles builds with or without AIP_DEMUX_OVERFLOW_EN.
module tb_aip_parametric_demux_reg;

  localparam int DW    = 32;
  localparam int SB    = 2;
  localparam int NSLOT = 4;

  logic            clk;
  logic            rst;
  logic            clear;
  logic            wr_en;
  logic            auto_inc;
  logic [SB-1:0]   sel;
  logic [DW-1:0]   data_in;
  logic            ready;
  logic [NSLOT*DW-1:0] data_out;
  logic [NSLOT-1:0]    slot_valid;
  logic [SB-1:0]   wr_ptr;
  logic            full;
  logic            done;
`ifdef AIP_DEMUX_OVERFLOW_EN
  logic            overflow;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: plain per-slot storage and flags.
  logic [DW-1:0] m_mem [NSLOT];
  bit            m_vld [NSLOT];
  int            m_ptr;
  bit            m_done;
  bit            m_ovf;

  aip_parametric_demux_reg #(
    .DATAWIDTH (DW),
    .SELBITS   (SB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_en      (wr_en),
    .auto_inc   (auto_inc),
    .sel        (sel),
    .data_in    (data_in),
    .ready      (ready),
    .data_out   (data_out),
    .slot_valid (slot_valid),
    .wr_ptr     (wr_ptr),
    .full       (full),
    .done       (done)
`ifdef AIP_DEMUX_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_full();
    for (int i = 0; i < NSLOT; i++) if (!m_vld[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [NSLOT*DW-1:0] m_bus();
    logic [NSLOT*DW-1:0] b;
    for (int i = 0; i < NSLOT; i++) b[i*DW +: DW] = m_mem[i];
    return b;
  endfunction

  function automatic logic [NSLOT-1:0] m_vbits();
    logic [NSLOT-1:0] v;
    for (int i = 0; i < NSLOT; i++) v[i] = m_vld[i];
    return v;
  endfunction

  // One clock cycle: drive, check ready, clock, update model, compare outputs.
  task automatic step(input bit r, input bit c, input bit w, input bit a,
                      input logic [SB-1:0] s, input logic [DW-1:0] d);
    bit was_full;
    bit exp_rdy;
    int t;
    rst = r; clear = c; wr_en = w; auto_inc = a; sel = s; data_in = d;
    #1;
    was_full = m_full();
    exp_rdy  = !c && !(a && was_full);
    if (!r) check("ready", ready, exp_rdy);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < NSLOT; i++) begin
        m_mem[i] = '0;
        m_vld[i] = 1'b0;
      end
      m_ptr = 0; m_done = 1'b0; m_ovf = 1'b0;
    end else if (c) begin
      for (int i = 0; i < NSLOT; i++) m_vld[i] = 1'b0;
      m_ptr = 0; m_done = 1'b0; m_ovf = 1'b0;
    end else begin
      if (w && a && was_full) m_ovf = 1'b1;
      if (w && exp_rdy) begin
        t = a ? m_ptr : int'(s);
        m_mem[t] = d;
        m_vld[t] = 1'b1;
        if (a) m_ptr = (m_ptr + 1) % NSLOT;
      end
      m_done = !was_full && m_full();
    end
    #1;
    check("data_out", data_out, m_bus());
    check("slot_valid", slot_valid, m_vbits());
    check("wr_ptr", wr_ptr, m_ptr);
    check("full", full, m_full());
    check("done", done, m_done);
`ifdef AIP_DEMUX_OVERFLOW_EN
    check("overflow", overflow, m_ovf);
`endif
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; wr_en = 1'b0; auto_inc = 1'b0; sel = '0; data_in = '0;
    for (int i = 0; i < NSLOT; i++) begin
      m_mem[i] = '0;
      m_vld[i] = 1'b0;
    end
    m_ptr = 0; m_done = 1'b0; m_ovf = 1'b0;

    // Reset state
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("rst_data", data_out, 128'h0);
    check("rst_valid", slot_valid, 4'b0000);
    check("rst_full", full, 1'b0);

    // Auto-increment fill
    step(0, 0, 1, 1, 0, 32'hA0);
    step(0, 0, 1, 1, 0, 32'hA1);
    step(0, 0, 1, 1, 0, 32'hA2);
    check("fill_no_early_done", done, 1'b0);
    step(0, 0, 1, 1, 0, 32'hA3);
    check("fill_data", data_out, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check("fill_valid", slot_valid, 4'b1111);
    check("fill_ptr", wr_ptr, 2'd0);
    check("fill_done", done, 1'b1);
    check("fill_full", full, 1'b1);
    step(0, 0, 0, 0, 0, 0);
    check("done_one_cycle", done, 1'b0);

    // Auto write while FULL is dropped
    step(0, 0, 1, 1, 0, 32'hFF);
    check("drop_data", data_out, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
`ifdef AIP_DEMUX_OVERFLOW_EN
    check("drop_overflow", overflow, 1'b1);
`endif
    step(0, 1, 0, 0, 0, 0);
    check("clr_valid", slot_valid, 4'b0000);
    check("clr_full", full, 1'b0);
    check("clr_data", data_out, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
`ifdef AIP_DEMUX_OVERFLOW_EN
    check("clr_overflow", overflow, 1'b0);
`endif

    // Addressed overwrite
    step(0, 0, 1, 0, 2, 32'h22);
    step(0, 0, 1, 0, 2, 32'h33);
    check("addr_slot2", data_out[95:64], 32'h33);
    check("addr_valid", slot_valid, 4'b0100);
    check("addr_ptr", wr_ptr, 2'd0);
    check("addr_done", done, 1'b0);

    // clear beats a simultaneous write
    step(0, 1, 1, 0, 1, 32'h55);
    check("clrwr_valid", slot_valid, 4'b0000);
    check("clrwr_slot1", data_out[63:32], 32'hA1);

    // Mixed addressed / auto
    step(0, 0, 1, 0, 0, 32'h10);
    step(0, 0, 1, 0, 3, 32'h13);
    step(0, 0, 1, 1, 0, 32'h20);
    step(0, 0, 1, 1, 0, 32'h21);
    check("mix_valid", slot_valid, 4'b1011);
    check("mix_ptr", wr_ptr, 2'd2);
    check("mix_no_done", done, 1'b0);
    step(0, 0, 1, 1, 0, 32'h22);
    check("mix_done", done, 1'b1);
    check("mix_full", full, 1'b1);
    check("mix_data", data_out, {32'h13, 32'h22, 32'h21, 32'h20});

    // Reset mid-frame
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 32'h61);
    step(0, 0, 1, 1, 0, 32'h62);
    step(1, 0, 0, 0, 0, 0);
    check("mrst_data", data_out, 128'h0);
    check("mrst_valid", slot_valid, 4'b0000);
    check("mrst_ptr", wr_ptr, 2'd0);
    step(0, 0, 1, 1, 0, 32'h77);
    check("mrst_slot0", data_out[31:0], 32'h77);
    check("mrst_valid1", slot_valid, 4'b0001);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
           $urandom_range(0, 99) < 70, 1'($urandom_range(0, 1)),
           SB'($urandom), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
